// File: rtl/shred_sequencer.sv
// shred_sequencer: steps a row-streaming Game-of-Life engine over a grid
// held in a single-port-per-direction row memory. Each generation resets the
// shredder lanes, streams every row into them top to bottom, writes each
// lane result back in place two rows behind the read pointer, and then
// feeds two dead rows so that the last two rows can be written back.
module shred_sequencer #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = 3,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GEN_W-1:0]  num_gens,
    output logic              busy,
    output logic              done,
    output logic [GEN_W-1:0]  gen_count,
    output logic              lane_rst,
    output logic [WIDTH-1:0]  lane_din,
    input  logic [WIDTH-1:0]  lane_next,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WIDTH-1:0]  mem_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Row index of the last grid row and of the first row written by DRAIN.
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] DRAIN_ROW = ADDR_W'(HEIGHT - 2);

    state_t              state_q, state_d;
    // Row index inside FEED, cycle index (0/1) inside DRAIN.
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [GEN_W-1:0]    gen_count_q, gen_count_d;
    logic [GEN_W-1:0]    num_gens_q, num_gens_d;
    logic [GEN_W-1:0]    gen_inc;
    logic                run_state;
    logic                feed_last;
    logic                feed_writes;

    // Generation count after the one currently draining completes. It never
    // wraps: it is only formed while gen_count < num_gens <= 2^GEN_W-1.
    assign gen_inc     = gen_count_q + GEN_W'(1);
    assign run_state   = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
    assign feed_last   = (idx_q == LAST_ROW);
    // Lanes need rows i-3..i-1 before row i-2 is ready, so writes start at i=2.
    assign feed_writes = (int'(idx_q) >= 2);

    // State, row index, generation counter and latched run length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            gen_count_q <= '0;
            num_gens_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gen_count_q <= gen_count_d;
            num_gens_q  <= num_gens_d;
        end
    end

    // Next-state logic; abort overrides every transition of a running sweep.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gen_count_d = gen_count_q;
        num_gens_d  = num_gens_q;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) begin
                    gen_count_d = '0;
                    num_gens_d  = num_gens;
                    state_d     = (num_gens != '0) ? S_CLEAR : S_FINISH;
                end
            end
            S_CLEAR: begin
                idx_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (feed_last) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (idx_q == '0) begin
                    idx_d = ADDR_W'(1);
                end else begin
                    idx_d       = '0;
                    gen_count_d = gen_inc;
                    state_d     = (gen_inc < num_gens_q) ? S_CLEAR : S_FINISH;
                end
            end
            S_FINISH: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (abort && run_state) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            gen_count_d = gen_count_q;
        end
    end

    // Output decode: lane control and memory port drive per state and row index.
    always_comb begin
        busy        = run_state;
        done        = (state_q == S_FINISH);
        gen_count   = gen_count_q;
        lane_rst    = 1'b0;
        lane_din    = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                lane_rst = 1'b1;
            end
            S_CLEAR: begin
                // Clear the lane history and prefetch row 0.
                lane_rst    = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = '0;
            end
            S_FEED: begin
                lane_din = mem_rd_data;
                if (!feed_last) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = idx_q + ADDR_W'(1);
                end
                if (feed_writes) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = idx_q - ADDR_W'(2);
                    mem_wr_data = lane_next;
                end
            end
            S_DRAIN: begin
                // Dead rows below the grid flush the last two results.
                mem_wr_en   = 1'b1;
                mem_wr_addr = DRAIN_ROW + idx_q;
                mem_wr_data = lane_next;
            end
            S_FINISH: begin
                lane_rst = 1'b1;
            end
            default: begin
                lane_rst = 1'b1;
            end
        endcase
    end

endmodule
